// File: rtl/timer_dev.sv
// timer_dev: programmable prescaled timer/compare peripheral on the SBA bus with level interrupt.
// Define TIMER_CAPTURE_EN to add the synchronised i_capture input, CAPTURE register and STATUS.CAP.
module timer_dev #(
    parameter int          PRESCALE_W    = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stb,
    input  logic [3:0]  i_we,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_dat_w,
    output logic [31:0] o_dat_r,
    output logic        o_ack,
    input  logic        i_capture,
    output logic        o_irq
);
    logic [2:0]            r_ctrl;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic [2:0]            r_status;
    logic                  r_ack;
    logic                  r_irq;
    logic [31:0]           r_dat_r;

    logic        w_acc;
    logic        w_wr;
    logic [2:0]  w_sel;
    logic        w_cnt_wr;
    logic        w_tick;
    logic        w_hit;
    logic        w_reload;
    logic        w_cap_set;
    logic [31:0] w_capture;
    logic [31:0] w_rdata;
    logic [31:0] w_merged;
    logic [2:0]  w_set;
    logic [2:0]  w_clr;
    logic        w_unused;

    assign w_acc    = i_stb && !r_ack;
    assign w_wr     = w_acc && (i_we != 4'b0000);
    assign w_sel    = i_addr[4:2];
    assign w_cnt_wr = w_wr && (w_sel == 3'd2);
    // A COUNT write in a tick cycle swallows the tick entirely, including its MATCH/OVF effects.
    assign w_tick   = r_ctrl[0] && (r_pcnt == '0) && !w_cnt_wr;
    assign w_hit    = r_count == r_compare;
    assign w_reload = w_hit && r_ctrl[2];
    assign w_unused = &{1'b0, i_addr[1:0], i_capture};

    assign w_rdata = (w_sel == 3'd0) ? {29'b0, r_ctrl} :
                     (w_sel == 3'd1) ? 32'(r_prescale) :
                     (w_sel == 3'd2) ? r_count :
                     (w_sel == 3'd3) ? r_compare :
                     (w_sel == 3'd4) ? {29'b0, r_status} :
                     (w_sel == 3'd5) ? w_capture : 32'b0;

    always_comb begin
        w_merged = w_rdata;
        for (int b = 0; b < 4; b++)
            w_merged[8*b +: 8] = i_we[b] ? i_dat_w[8*b +: 8] : w_rdata[8*b +: 8];
    end

    assign w_set = {w_cap_set,
                    w_tick && !w_reload && (r_count == 32'hFFFF_FFFF),
                    w_tick && w_hit};
    assign w_clr = (w_wr && (w_sel == 3'd4) && i_we[0]) ? i_dat_w[2:0] : 3'b000;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_count    <= '0;
            r_compare  <= RESET_COMPARE;
            r_status   <= '0;
            r_ack      <= 1'b0;
            r_dat_r    <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_ack <= w_acc;
            if (w_acc)
                r_dat_r <= w_wr ? 32'b0 : w_rdata;
            if (w_wr && (w_sel == 3'd0))
                r_ctrl <= w_merged[2:0];
            if (w_wr && (w_sel == 3'd1))
                r_prescale <= w_merged[PRESCALE_W-1:0];
            if (w_wr && (w_sel == 3'd3))
                r_compare <= w_merged;
            if (w_cnt_wr)
                r_count <= w_merged;
            else if (w_tick)
                r_count <= w_reload ? 32'b0 : r_count + 32'd1;
            r_pcnt   <= (!r_ctrl[0] || (r_pcnt == '0)) ? r_prescale : r_pcnt - PRESCALE_W'(1);
            r_status <= (r_status & ~w_clr) | w_set;
            r_irq    <= r_ctrl[1] && (r_status != 3'b000);
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [2:0]  r_cap_sync;
    logic [31:0] r_capture;

    // Two synchroniser stages plus one history flop for rising-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cap_sync <= '0;
            r_capture  <= '0;
        end else begin
            r_cap_sync <= {r_cap_sync[1:0], i_capture};
            if (w_cap_set)
                r_capture <= r_count;
        end
    end

    assign w_cap_set = r_cap_sync[1] && !r_cap_sync[2];
    assign w_capture = r_capture;
`else
    assign w_cap_set = 1'b0;
    assign w_capture = 32'b0;
`endif

    assign o_ack   = r_ack;
    assign o_dat_r = r_dat_r;
    assign o_irq   = r_irq;
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed self-checking bench for timer_dev.
module tb_timer_dev;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        cap = 1'b0;
    logic [3:0]  we = 4'b0;
    logic [4:0]  addr = 5'b0;
    logic [31:0] dat_w = 32'b0;
    logic [31:0] dat_r;
    logic        ack;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_e = 0;
    int          p = 0;
    int          n = 0;
    logic        irq_e;
    logic        irq_e1;
    logic [31:0] rd;

    timer_dev dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stb(stb), .i_we(we), .i_addr(addr),
        .i_dat_w(dat_w), .o_dat_r(dat_r), .o_ack(ack), .i_capture(cap), .o_irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [4:0] a, input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        stb = 1'b1; addr = a; we = w; dat_w = d;
        @(posedge clk); #1;
        check("ack_rise", ack, 1);
        rd = dat_r; last_e = cyc; irq_e = irq;
        stb = 1'b0; we = 4'b0;
        @(posedge clk); #1;
        check("ack_fall", ack, 0);
        irq_e1 = irq;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        xfer(a, 4'hF, d);
        check("wr_dat_zero", rd, 0);
    endtask

    task automatic rdchk(input logic [4:0] a, input logic [31:0] exp, input string tag);
        xfer(a, 4'h0, 32'b0);
        check(tag, rd, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_irq", irq, 0);
        check("rst_dat", dat_r, 0);
        @(negedge clk) rst_n = 1'b1;
        rdchk(5'h00, 32'h0, "rst_ctrl");
        rdchk(5'h0C, 32'hFFFF_FFFF, "rst_compare");
        rdchk(5'h10, 32'h0, "rst_status");
        rdchk(5'h14, 32'h0, "rst_capture");

        // periodic compare with auto-reload, one increment per 4 cycles
        wr(5'h04, 32'd3);
        wr(5'h0C, 32'd5);
        wr(5'h00, 32'd7);
        p = last_e;
        for (int i = 0; i < 14; i++) begin
            xfer(5'h08, 4'h0, 32'b0);
            n = last_e - 1 - p;
            check("count_seq", rd, 32'((n / 4) % 6));
            check("irq_seq", irq_e, (last_e - p >= 25) ? 1 : 0);
        end
        rdchk(5'h10, 32'h1, "match_only");
        wr(5'h00, 32'h0);
        wr(5'h10, 32'h7);
        rdchk(5'h10, 32'h0, "status_clr");
        check("irq_clr", irq_e, 0);

        // overflow then match with prescale 0
        wr(5'h08, 32'hFFFF_FFFE);
        wr(5'h04, 32'h0);
        wr(5'h0C, 32'h0);
        wr(5'h00, 32'h3);
        @(posedge clk);
        rdchk(5'h10, 32'h2, "ovf_first");
        check("irq_ovf", irq_e, 1);
        rdchk(5'h10, 32'h3, "ovf_then_match");
        wr(5'h10, 32'h3);
        check("irq_lag", irq_e, 1);
        check("irq_drop", irq_e1, 0);
        rdchk(5'h10, 32'h0, "w1c_both");
        wr(5'h00, 32'h0);
        wr(5'h08, 32'h77);
        rdchk(5'h08, 32'h77, "count_frozen_a");
        rdchk(5'h08, 32'h77, "count_frozen_b");

        // byte lanes and unused upper bits
        wr(5'h0C, 32'hFFFF_FFFF);
        xfer(5'h0C, 4'b0010, 32'h0000_AB00);
        rdchk(5'h0C, 32'hFFFF_ABFF, "byte_lane");
        wr(5'h00, 32'hFFFF_FFF8);
        rdchk(5'h00, 32'h0, "ctrl_upper");
        xfer(5'h04, 4'b0001, 32'h1234_5678);
        rdchk(5'h04, 32'h78, "prescale_lane");
        wr(5'h04, 32'h0);
        rdchk(5'h18, 32'h0, "reserved_rd");

        // COUNT write beats a coincident tick
        wr(5'h0C, 32'h500);
        wr(5'h00, 32'h1);
        wr(5'h08, 32'h100);
        rdchk(5'h08, 32'h101, "cnt_wr_wins");

        // hardware MATCH set in the same cycle as its W1C
        wr(5'h00, 32'h0);
        wr(5'h10, 32'h7);
        wr(5'h0C, 32'h101);
        wr(5'h00, 32'h1);
        wr(5'h08, 32'h100);
        wr(5'h10, 32'h1);
        rdchk(5'h10, 32'h1, "w1c_vs_set");
        wr(5'h10, 32'h1);
        rdchk(5'h10, 32'h0, "w1c_plain");

        // capture input
        wr(5'h00, 32'h0);
        wr(5'h08, 32'h42);
        wr(5'h10, 32'h7);
        @(negedge clk) cap = 1'b1;
        repeat (2) @(negedge clk);
        cap = 1'b0;
        repeat (4) @(posedge clk);
`ifdef TIMER_CAPTURE_EN
        rdchk(5'h14, 32'h42, "capture_val");
        rdchk(5'h10, 32'h4, "capture_flag");
`else
        rdchk(5'h14, 32'h0, "capture_off");
        rdchk(5'h10, 32'h0, "capture_flag_off");
`endif

        // async reset in the middle of a transfer
        @(negedge clk);
        stb = 1'b1; addr = 5'h0C; we = 4'h0;
        @(posedge clk); #1;
        check("mid_ack", ack, 1);
        check("mid_dat", dat_r, 32'h101);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack_drop", ack, 0);
        check("rst_dat_drop", dat_r, 0);
        stb = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        rdchk(5'h0C, 32'hFFFF_FFFF, "post_rst_compare");
        rdchk(5'h08, 32'h0, "post_rst_count");
        rdchk(5'h00, 32'h0, "post_rst_ctrl");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Programmable timer/compare peripheral on the SoC external SBA bus; decoded at ext_addr[15:12] == 4'h4 in the board top.
- Consumes SoC bus cycles like the other external devices (cfg/led/uart/spi).
- Produces a level interrupt and a wrap-tagged 32-bit free-running/periodic count for software delays and scheduling.

Parameters:
- PRESCALE_W, 16, width of prescaler reload register (1..32).
- RESET_COMPARE, 32'hFFFF_FFFF, reset value of COMPARE.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_stb  input  1  bus strobe, already qualified by address decode
- i_we  input  4  byte write enables; 4'b0000 = read
- i_addr  input  5  byte offset within device; bits [1:0] ignored
- i_dat_w  input  32  write data
- o_dat_r  output  32  read data, valid while o_ack high
- o_ack  output  1  one-cycle acknowledge
- i_capture  input  1  asynchronous capture strobe (used only with TIMER_CAPTURE_EN)
- o_irq  output  1  level interrupt

Behaviour:
- Reset (async assert, sync deassert handled upstream): CTRL=0, PRESCALE=0, prescaler counter=0, COUNT=0, COMPARE=RESET_COMPARE, STATUS=0, CAPTURE=0, o_ack=0, o_dat_r=0, o_irq=0.
- Register map (i_addr[4:2]):
  - 0 CTRL: [0] EN, [1] IRQ_EN, [2] AUTO_RELOAD.
  - 1 PRESCALE.
  - 2 COUNT.
  - 3 COMPARE.
  - 4 STATUS: [0] MATCH, [1] OVF; write-1-to-clear.
  - 5 CAPTURE (read-only).
  - 6-7 read 0, writes ignored.
- Handshake:
  - Access accepted when i_stb && !o_ack.
  - o_ack registered high exactly one cycle later, then low for at least one cycle.
  - Master holds i_stb/i_addr/i_dat_w until ack.
  - Back-to-back accesses therefore take 2 cycles each.
  - o_dat_r registered with ack; holds value of the accepted read, 0 for writes.
- Writes: honour each i_we byte lane independently; unused upper bits of CTRL/PRESCALE/STATUS read 0.
- Prescaler:
  - While EN, the prescaler counts down from PRESCALE.
  - At 0 it emits a one-cycle tick and reloads.
  - PRESCALE=0 gives a tick every cycle.
  - EN=0 holds the prescaler at PRESCALE and suppresses ticks.
- On tick:
  - If COUNT==COMPARE: set MATCH; if AUTO_RELOAD, COUNT<=0, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1.
  - Transition FFFF_FFFF->0 by increment sets OVF; an auto-reload to 0 does not.
- Priority:
  - A bus write to COUNT in the same cycle as a tick wins; that tick is lost.
  - A bus write of PRESCALE takes effect at the next reload.
  - W1C of a STATUS bit in the same cycle the hardware sets it leaves the bit set.
- o_irq: registered, = IRQ_EN && (MATCH || OVF); one-cycle lag from the STATUS update.
- Write CTRL.EN 1->0 mid-count freezes COUNT and STATUS; re-enable resumes from the frozen value.
- Async reset mid-transfer: o_ack drops immediately; the transfer is abandoned.

Optional Feature:
- Macro TIMER_CAPTURE_EN.
- With it:
  - i_capture passes through a 2-flop synchroniser plus edge detector.
  - A rising edge latches the current COUNT into CAPTURE and sets STATUS[2] CAP (W1C).
  - CAP contributes to o_irq.
  - Capture latency is 3 cycles from pin edge to CAPTURE update.
  - A capture coincident with a COUNT increment latches the pre-increment value.
- Without it:
  - i_capture is ignored.
  - CAPTURE and STATUS[2] read 0.
  - No synchroniser flops.

Test Plan:
- Reset then read offsets 0x00/0x0C/0x10 -> 0, FFFF_FFFF, 0; each ack exactly 1 cycle after stb, o_ack low the following cycle.
- PRESCALE=3, COMPARE=5, CTRL=3'b111 -> COUNT 0..5 with one increment every 4 cycles, MATCH and o_irq rise one cycle apart, COUNT returns to 0, pattern repeats.
- COUNT=FFFF_FFFE, PRESCALE=0, AUTO_RELOAD=0, COMPARE=0, EN=1 -> OVF set after 2 ticks, MATCH one tick later; write STATUS=3 -> STATUS 0, o_irq low next cycle.
- Byte-lane write i_we=4'b0010 data 0x0000_AB00 to COMPARE -> COMPARE=FFFF_ABFF.
- Bus write COUNT=0x100 in a tick cycle -> COUNT=0x100 next cycle, not 0x101; hardware MATCH set coincident with W1C -> MATCH stays 1.
- (TIMER_CAPTURE_EN) pulse i_capture while COUNT=0x42 steady, EN=0 -> CAPTURE=0x42, CAP=1 after 3 cycles; without the macro, CAPTURE reads 0.
